mealy_frame_scan_ctrl: RTL and testbench
========================================

Name: mealy_frame_scan_ctrl

Overview:
Frame-level controller that sequences a Mealy-style serial pattern detector. It accepts a parallel word and a pattern/mode configuration over a valid/ready handshake, then serializes the word MSB-first into its internal detector, one bit per clock. It counts detections in either overlapping or non-overlapping mode and returns a per-frame result over a second valid/ready handshake. It replaces hand-driven bit stimulus in front of the 11011-style detectors with a reusable, configurable front end.

Parameters:
WORD_W, 16, frame width in bits; shifted MSB-first.
PAT_LEN, 5, pattern length in bits; 2 <= PAT_LEN <= WORD_W.
CNT_W, 5, match counter width; counter saturates at 2^CNT_W-1.
POS_W, 5, position field width; WORD_W < 2^POS_W.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  frame request.
in_ready  output  1  high only in IDLE.
in_word  input  WORD_W  frame data.
pattern  input  PAT_LEN  pattern; MSB is the first bit in time.
overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
det_pulse  output  1  Mealy detect strobe; combinational in SHIFT.
busy  output  1  high in SHIFT or REPORT.
out_valid  output  1  result valid; high in REPORT.
out_ready  input  1  result accept.
match_count  output  CNT_W  detections in the last frame.
first_pos  output  POS_W  bit index (0 = first shifted) of the last bit of the first match; all-ones if no match.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE; in_ready = 1; busy = 0; out_valid = 0; det_pulse = 0; match_count = 0; first_pos = all-ones.
- All internal registers clear on reset: word, pattern, mode, bit index, history, fill. Reset asserted mid-frame aborts the frame and produces no result.
- States: IDLE, SHIFT, REPORT.
- IDLE -> SHIFT on an edge with in_valid && in_ready:
  - Capture in_word, pattern and overlap.
  - Clear history, fill, match_count and first_pos.
  - Set bit index idx = 0.
- SHIFT, one bit per cycle:
  - Current bit b = word[WORD_W-1-idx].
  - Window = {history[PAT_LEN-2:0], b}.
  - Hit condition: fill >= PAT_LEN-1 and window == pattern.
  - det_pulse = hit, combinational and valid in the same cycle as b.
- At each SHIFT edge:
  - history shifts in b.
  - On a hit: match_count increments, saturating at 2^CNT_W-1. If this is the first hit of the frame, first_pos = idx.
  - fill update: a hit in non-overlap mode sets fill = 0. Otherwise fill = min(fill+1, PAT_LEN-1).
  - idx increments. When idx = WORD_W-1 the edge moves the state to REPORT.
- Latency: the handshake edge is followed by exactly WORD_W SHIFT cycles. out_valid rises on the edge after the last bit.
- REPORT:
  - out_valid = 1; match_count and first_pos are held stable.
  - Stays in REPORT while out_ready = 0 (backpressure, held indefinitely).
  - On out_valid && out_ready, goes to IDLE. Outputs keep their last values until the next frame is accepted.
- in_valid is ignored outside IDLE. in_word, pattern and overlap may change freely after capture without effect.
- Detector history never carries across frames.
- det_pulse = 0 outside SHIFT.
- Simultaneous hit and saturation: the count stays at its maximum, and first_pos still updates if this is the first hit.

Test Plan:
1. Reset with rst=1, then release. Send in_word=16'hDB6C (1101101101101100), pattern=5'b11011, overlap=0 -> det_pulse at idx 4 and 10; match_count=2; first_pos=4; out_valid rises exactly 16 cycles after the handshake edge.
2. Same word and pattern, overlap=1 -> det_pulse at idx 4, 7, 10, 13; match_count=4; first_pos=4.
3. in_word=16'hFFFF, pattern=5'b11111 -> overlap=1: count 12, first_pos=4. overlap=0: hits at 4, 9, 14, count 3.
4. in_word=16'h0000, pattern=5'b11011 -> match_count=0; first_pos=31; det_pulse never asserts. With CNT_W=3 override, 16'hFFFF, pattern 11111, overlap=1 -> match_count saturates at 7.
5. Hold out_ready=0 for 10 cycles in REPORT -> out_valid, match_count and first_pos stay stable, in_ready=0, and an in_valid pulse is ignored. Then out_ready=1 -> IDLE next edge, in_ready=1.
6. Assert rst asynchronously (between clock edges) at idx=7 of a frame -> outputs return immediately to reset values with no out_valid. The next frame processes correctly with no leftover history.

Source files
------------

// File: rtl/mealy_frame_scan_ctrl.sv
// Frame front end for a Mealy serial pattern detector: captures a word plus
// pattern/mode, shifts it MSB-first through the detector, and reports the match count and first match position.
module mealy_frame_scan_ctrl #(
  parameter int WORD_W  = 16,
  parameter int PAT_LEN = 5,
  parameter int CNT_W   = 5,
  parameter int POS_W   = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WORD_W-1:0]  in_word,
  input  logic [PAT_LEN-1:0] pattern,
  input  logic               overlap,
  output logic               det_pulse,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CNT_W-1:0]   match_count,
  output logic [POS_W-1:0]   first_pos
);
  localparam int FILL_W = (PAT_LEN > 2) ? $clog2(PAT_LEN) : 1;
  localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_LEN-1);
  localparam logic [POS_W-1:0]  IDX_LAST = POS_W'(WORD_W-1);

  typedef enum logic [1:0] {IDLE, SHIFT, REPORT} state_e;

  state_e             state_q, state_d;
  logic [WORD_W-1:0]  word_q, word_d;
  logic [PAT_LEN-1:0] pat_q, pat_d;
  logic               ovl_q, ovl_d;
  logic [POS_W-1:0]   idx_q, idx_d;
  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [POS_W-1:0]   fpos_q, fpos_d;

  logic [PAT_LEN-1:0] window;
  logic               hit;

  // The word register shifts left each bit, so the current bit is always its MSB.
  assign window = {hist_q, word_q[WORD_W-1]};
  assign hit    = (fill_q == FILL_MAX) && (window == pat_q);

  assign match_count = cnt_q;
  assign first_pos   = fpos_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      word_q  <= '0;
      pat_q   <= '0;
      ovl_q   <= 1'b0;
      idx_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      fpos_q  <= '1;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      pat_q   <= pat_d;
      ovl_q   <= ovl_d;
      idx_q   <= idx_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      fpos_q  <= fpos_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    pat_d     = pat_q;
    ovl_d     = ovl_q;
    idx_d     = idx_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    cnt_d     = cnt_q;
    fpos_d    = fpos_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    det_pulse = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          word_d  = in_word;
          pat_d   = pattern;
          ovl_d   = overlap;
          idx_d   = '0;
          hist_d  = '0;
          fill_d  = '0;
          cnt_d   = '0;
          fpos_d  = '1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        busy      = 1'b1;
        det_pulse = hit;
        word_d    = word_q << 1;
        hist_d    = window[PAT_LEN-2:0];
        idx_d     = idx_q + 1'b1;
        if (hit) begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
          // All-ones is never a legal index, so it doubles as "no hit yet".
          if (fpos_q == '1) fpos_d = idx_q;
        end
        if (hit && !ovl_q)          fill_d = '0;
        else if (fill_q != FILL_MAX) fill_d = fill_q + 1'b1;
        if (idx_q == IDX_LAST) state_d = REPORT;
      end
      REPORT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mealy_frame_scan_ctrl.sv
// Directed and random frames against a window-scan reference model; a second
// instance with a 3-bit counter exercises saturation on the same stimulus.
module tb_mealy_frame_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, overlap;
  logic [15:0] in_word;
  logic [4:0]  pattern;
  logic        in_ready, det_pulse, busy, out_valid;
  logic [4:0]  match_count, first_pos;
  logic        in_ready3, det_pulse3, busy3, out_valid3;
  logic [2:0]  match_count3;
  logic [4:0]  first_pos3;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  mealy_frame_scan_ctrl #(.WORD_W(16), .PAT_LEN(5), .CNT_W(5), .POS_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .pattern(pattern), .overlap(overlap),
    .det_pulse(det_pulse), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .match_count(match_count), .first_pos(first_pos));

  mealy_frame_scan_ctrl #(.WORD_W(16), .PAT_LEN(5), .CNT_W(3), .POS_W(5)) dut3 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
    .in_word(in_word), .pattern(pattern), .overlap(overlap),
    .det_pulse(det_pulse3), .busy(busy3), .out_valid(out_valid3),
    .out_ready(out_ready), .match_count(match_count3), .first_pos(first_pos3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: a match ends at bit i when the 5 bits ending at i equal the
  // pattern; non-overlapping mode needs the match to start after the last one ended.
  function automatic void model(input logic [15:0] w, input logic [4:0] p, input bit ov,
                                output logic [15:0] hits, output int cnt, output int fp);
    int last = -1;
    hits = '0; cnt = 0; fp = 31;
    for (int i = 4; i < 16; i++) begin
      logic [15:0] sh;
      sh = w >> (15 - i);
      if (sh[4:0] == p && (ov || i - last >= 5)) begin
        hits[i] = 1'b1;
        cnt++;
        if (fp == 31) fp = i;
        last = i;
      end
    end
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, ".in_ready"}, in_ready, 1);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".out_valid"}, out_valid, 0);
    chk({tag, ".det_pulse"}, det_pulse, 0);
    chk({tag, ".match_count"}, match_count, 0);
    chk({tag, ".first_pos"}, first_pos, 31);
  endtask

  // Runs one frame; abort_at >= 0 asserts reset mid-frame at that bit index.
  task automatic run_frame(input logic [15:0] w, input logic [4:0] p, input bit ov,
                           input int stall, input int abort_at);
    logic [15:0] hits;
    int cnt, fp, guard;
    model(w, p, ov, hits, cnt, fp);
    @(negedge clk);
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_in_ready", in_ready, 1);
    in_valid = 1'b1; in_word = w; pattern = p; overlap = ov;
    @(negedge clk);
    // Scramble inputs after capture: they must have no effect.
    in_valid = 1'b0; in_word = $urandom; pattern = $urandom; overlap = $urandom;
    for (int i = 0; i < 16; i++) begin
      if (i == abort_at) begin
        #2 rst = 1'b1;
        #1 check_reset_outputs("abort");
        @(negedge clk);
        chk("abort.no_out_valid", out_valid, 0);
        rst = 1'b0;
        return;
      end
      chk($sformatf("det_pulse[%0d]", i), det_pulse, hits[i]);
      chk($sformatf("det_pulse3[%0d]", i), det_pulse3, hits[i]);
      if (i == 0 || i == 15) begin
        chk("shift.busy", busy, 1);
        chk("shift.out_valid", out_valid, 0);
        chk("shift.in_ready", in_ready, 0);
      end
      @(negedge clk);
    end
    chk("report.out_valid", out_valid, 1);
    chk("report.match_count", match_count, cnt);
    chk("report.first_pos", first_pos, fp);
    chk("report.match_count3", match_count3, (cnt > 7) ? 7 : cnt);
    chk("report.first_pos3", first_pos3, fp);
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      @(negedge clk);
      chk("stall.out_valid", out_valid, 1);
      chk("stall.in_ready", in_ready, 0);
      chk("stall.match_count", match_count, cnt);
      chk("stall.first_pos", first_pos, fp);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("done.in_ready", in_ready, 1);
    chk("done.out_valid", out_valid, 0);
    chk("done.busy", busy, 0);
    chk("done.match_count_held", match_count, cnt);
    chk("done.first_pos_held", first_pos, fp);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; overlap = 1'b0;
    in_word = '0; pattern = '0;
    #12 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    run_frame(16'hDB6C, 5'b11011, 1'b0, 0, -1);
    run_frame(16'hDB6C, 5'b11011, 1'b1, 0, -1);
    run_frame(16'hFFFF, 5'b11111, 1'b1, 0, -1);
    run_frame(16'hFFFF, 5'b11111, 1'b0, 0, -1);
    run_frame(16'h0000, 5'b11011, 1'b1, 0, -1);
    run_frame(16'hDB6C, 5'b11011, 1'b1, 10, -1);
    run_frame(16'hDB6C, 5'b11011, 1'b1, 0, 7);
    run_frame(16'h1B00, 5'b00001, 1'b0, 0, -1);
    for (int n = 0; n < 24; n++) begin
      logic [15:0] w;
      logic [4:0]  p;
      int          sh;
      w  = $urandom;
      sh = $urandom_range(0, 11);
      p  = (n % 3 == 0) ? 5'($urandom) : 5'(w >> sh);
      run_frame(w, p, 1'($urandom), $urandom_range(0, 3), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
